// File: rtl/mips_control_decoder_if.sv
// Avalon-side bus strobes between the MIPS control unit and the memory interconnect.
// The control unit is the master: it issues read/write strobes and byte lanes, the bus answers with waitrequest.
interface mips_control_decoder_if;
    logic       waitrequest;
    logic       MemRead;
    logic       MemWrite;
    logic [3:0] byteenable;

    modport master (
        input  waitrequest,
        output MemRead,
        output MemWrite,
        output byteenable
    );

    modport slave (
        output waitrequest,
        input  MemRead,
        input  MemWrite,
        input  byteenable
    );
endinterface

// File: rtl/mips_control_decoder.sv
// Multicycle control unit for the Avalon-bus MIPS-I CPU: FSM sequencing, instruction decode,
// bus strobes, branch delay slot tracking and halt on PC == 0.
module mips_control_decoder (
    input  logic        clk,
    input  logic        Rst,
    input  logic [31:0] Instr,
    input  logic        PCIs0,
    input  logic        lessthan,
    mips_control_decoder_if.master bus,
    output logic        Active,
    output logic [2:0]  State,
    output logic        IorD,
    output logic        IrWrite,
    output logic        IrSel,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [4:0]  ALUControl,
    output logic        ALUSel,
    output logic        ExtSel,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        Is_Jump,
    output logic        BranchDelay,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        Link,
    output logic        OutLSB,
    output logic [1:0]  extendedmem,
    output logic        stall,
    output logic        Stall
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_SLT   = 5'd5;
    localparam logic [4:0] ALU_SLTU  = 5'd6;
    localparam logic [4:0] ALU_SLL   = 5'd7;
    localparam logic [4:0] ALU_SRL   = 5'd8;
    localparam logic [4:0] ALU_SRA   = 5'd9;
    localparam logic [4:0] ALU_LUI   = 5'd10;
    localparam logic [4:0] ALU_EQ    = 5'd11;
    localparam logic [4:0] ALU_NE    = 5'd12;
    localparam logic [4:0] ALU_PASSA = 5'd13;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    logic [2:0] state;
    logic [2:0] next_state;
    logic       branch_delay;
    logic       took_branch;
    logic       taken;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_instr_bits;

    logic [4:0] d_alu;
    logic       d_srca;
    logic [1:0] d_srcb;
    logic       d_wr;
    logic       d_rdst;
    logic       d_load;
    logic       d_store;
    logic       d_branch;
    logic       d_jump_imm;
    logic       d_jump_reg;
    logic       d_link;
    logic       d_lsb;
    logic       d_ext;
    logic [1:0] d_extmem;

    assign opcode            = Instr[31:26];
    assign funct             = Instr[5:0];
    assign unused_instr_bits = ^Instr[25:6];

    // Instruction decode; anything unrecognised falls through as a NOP (no writes, straight to WB).
    always_comb begin
        d_alu      = ALU_ADD;
        d_srca     = 1'b0;
        d_srcb     = 2'd0;
        d_wr       = 1'b0;
        d_rdst     = 1'b0;
        d_load     = 1'b0;
        d_store    = 1'b0;
        d_branch   = 1'b0;
        d_jump_imm = 1'b0;
        d_jump_reg = 1'b0;
        d_link     = 1'b0;
        d_lsb      = 1'b0;
        d_ext      = 1'b1;
        d_extmem   = 2'd0;
        case (opcode)
            OP_RTYPE: begin
                d_srca = 1'b1;
                d_rdst = 1'b1;
                case (funct)
                    FN_ADDU: begin d_alu = ALU_ADD;  d_wr = 1'b1; end
                    FN_SUBU: begin d_alu = ALU_SUB;  d_wr = 1'b1; end
                    FN_AND:  begin d_alu = ALU_AND;  d_wr = 1'b1; end
                    FN_OR:   begin d_alu = ALU_OR;   d_wr = 1'b1; end
                    FN_XOR:  begin d_alu = ALU_XOR;  d_wr = 1'b1; end
                    FN_SLT:  begin d_alu = ALU_SLT;  d_wr = 1'b1; d_lsb = 1'b1; end
                    FN_SLTU: begin d_alu = ALU_SLTU; d_wr = 1'b1; d_lsb = 1'b1; end
                    FN_SLL:  begin d_alu = ALU_SLL;  d_wr = 1'b1; d_srcb = 2'd3; end
                    FN_SRL:  begin d_alu = ALU_SRL;  d_wr = 1'b1; d_srcb = 2'd3; end
                    FN_SRA:  begin d_alu = ALU_SRA;  d_wr = 1'b1; d_srcb = 2'd3; end
                    FN_JR:   begin d_alu = ALU_PASSA; d_jump_reg = 1'b1; end
                    FN_JALR: begin
                        d_alu      = ALU_PASSA;
                        d_jump_reg = 1'b1;
                        d_wr       = 1'b1;
                        d_link     = 1'b1;
                    end
                    default: d_srca = 1'b0;
                endcase
            end
            OP_ADDIU: begin d_alu = ALU_ADD;  d_srca = 1'b1; d_srcb = 2'd2; d_wr = 1'b1; end
            OP_SLTI:  begin d_alu = ALU_SLT;  d_srca = 1'b1; d_srcb = 2'd2; d_wr = 1'b1; d_lsb = 1'b1; end
            OP_SLTIU: begin d_alu = ALU_SLTU; d_srca = 1'b1; d_srcb = 2'd2; d_wr = 1'b1; d_lsb = 1'b1; end
            OP_ANDI:  begin d_alu = ALU_AND;  d_srca = 1'b1; d_srcb = 2'd2; d_wr = 1'b1; d_ext = 1'b0; end
            OP_ORI:   begin d_alu = ALU_OR;   d_srca = 1'b1; d_srcb = 2'd2; d_wr = 1'b1; d_ext = 1'b0; end
            OP_XORI:  begin d_alu = ALU_XOR;  d_srca = 1'b1; d_srcb = 2'd2; d_wr = 1'b1; d_ext = 1'b0; end
            OP_LUI:   begin d_alu = ALU_LUI;  d_srcb = 2'd2; d_wr = 1'b1; end
            OP_LW:    begin d_srca = 1'b1; d_srcb = 2'd2; d_wr = 1'b1; d_load = 1'b1; d_extmem = 2'd0; end
            OP_LB:    begin d_srca = 1'b1; d_srcb = 2'd2; d_wr = 1'b1; d_load = 1'b1; d_extmem = 2'd1; end
            OP_LBU:   begin d_srca = 1'b1; d_srcb = 2'd2; d_wr = 1'b1; d_load = 1'b1; d_extmem = 2'd2; d_ext = 1'b0; end
            OP_LH:    begin d_srca = 1'b1; d_srcb = 2'd2; d_wr = 1'b1; d_load = 1'b1; d_extmem = 2'd3; end
            OP_LHU:   begin d_srca = 1'b1; d_srcb = 2'd2; d_wr = 1'b1; d_load = 1'b1; d_extmem = 2'd3; d_ext = 1'b0; end
            OP_SW:    begin d_srca = 1'b1; d_srcb = 2'd2; d_store = 1'b1; end
            OP_BEQ:   begin d_alu = ALU_EQ; d_srca = 1'b1; d_branch = 1'b1; end
            OP_BNE:   begin d_alu = ALU_NE; d_srca = 1'b1; d_branch = 1'b1; end
            OP_J:     d_jump_imm = 1'b1;
            OP_JAL:   begin d_jump_imm = 1'b1; d_wr = 1'b1; d_link = 1'b1; end
            default:  d_ext = 1'b1;
        endcase
    end

    assign taken = d_jump_imm | d_jump_reg | (d_branch & lessthan);

    // Strobes are forced low combinationally while Rst is high so a reset mid-access drops the bus at once.
    always_comb begin
        next_state     = state;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.byteenable = 4'h0;
        IorD           = 1'b0;
        IrWrite        = 1'b0;
        IrSel          = 1'b0;
        ALUSrcA        = 1'b0;
        ALUSrcB        = 2'd0;
        ALUControl     = ALU_ADD;
        ALUSel         = 1'b0;
        ExtSel         = 1'b0;
        PCWrite        = 1'b0;
        PCSrc          = 1'b0;
        Is_Jump        = 1'b0;
        RegWrite       = 1'b0;
        RegDst         = 1'b0;
        MemtoReg       = 1'b0;
        Link           = 1'b0;
        OutLSB         = 1'b0;
        extendedmem    = 2'd0;
        stall          = 1'b0;
        if (!Rst) begin
            case (state)
                S_FETCH: begin
                    if (PCIs0) begin
                        next_state = S_HALT;
                    end else begin
                        bus.MemRead    = 1'b1;
                        bus.byteenable = 4'hF;
                        stall          = bus.waitrequest;
                        IrWrite        = ~bus.waitrequest;
                        IrSel          = ~bus.waitrequest;
                        if (!bus.waitrequest) next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    ALUSrcA    = 1'b0;
                    ALUSrcB    = 2'd1;
                    ALUControl = ALU_ADD;
                    ExtSel     = d_ext;
                    next_state = S_EXEC;
                end
                S_EXEC: begin
                    ALUSrcA    = d_srca;
                    ALUSrcB    = d_srcb;
                    ALUControl = d_alu;
                    // Effective addresses always sign-extend, even for the zero-extending loads.
                    ExtSel     = (d_load | d_store) ? 1'b1 : d_ext;
                    Is_Jump    = d_jump_imm;
                    ALUSel     = d_branch;
                    next_state = (d_load | d_store) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    bus.MemRead    = d_load;
                    bus.MemWrite   = d_store;
                    bus.byteenable = 4'hF;
                    IorD           = 1'b1;
                    ExtSel         = d_ext;
                    extendedmem    = d_extmem;
                    stall          = bus.waitrequest;
                    if (!bus.waitrequest) next_state = S_WB;
                end
                S_WB: begin
                    RegWrite    = d_wr;
                    RegDst      = d_wr & d_rdst;
                    MemtoReg    = d_load;
                    Link        = d_link;
                    OutLSB      = d_lsb;
                    extendedmem = d_extmem;
                    ExtSel      = d_ext;
                    ALUSrcA     = 1'b0;
                    ALUSrcB     = 2'd1;
                    ALUControl  = ALU_ADD;
                    PCWrite     = 1'b1;
                    // The branch's own WB advances sequentially; its delay slot's WB takes the target.
                    PCSrc       = branch_delay & ~took_branch;
                    next_state  = S_FETCH;
                end
                default: next_state = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state        <= S_FETCH;
            branch_delay <= 1'b0;
            took_branch  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_EXEC) begin
                took_branch <= taken;
                if (taken) branch_delay <= 1'b1;
            end else if (state == S_WB && branch_delay && !took_branch) begin
                branch_delay <= 1'b0;
            end
        end
    end

    assign State       = state;
    assign Active      = (state != S_HALT);
    assign BranchDelay = branch_delay;
    assign Stall       = stall;

endmodule

// File: tb/tb_mips_control_decoder.sv
// Bench for mips_control_decoder: table of instructions stepped through the FSM, with WB
// expectations queued at fetch and compared when the DUT reaches WB, plus reset/halt sequences.
module tb_mips_control_decoder;

    logic        clk;
    logic        Rst;
    logic [31:0] Instr;
    logic        PCIs0;
    logic        lessthan;
    logic        Active;
    logic [2:0]  State;
    logic        IorD, IrWrite, IrSel, ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [4:0]  ALUControl;
    logic        ALUSel, ExtSel, PCWrite, PCSrc, Is_Jump, BranchDelay;
    logic        RegWrite, RegDst, MemtoReg, Link, OutLSB;
    logic [1:0]  extendedmem;
    logic        stall, Stall;

    mips_control_decoder_if bus_if ();

    mips_control_decoder dut (
        .clk(clk), .Rst(Rst), .Instr(Instr), .PCIs0(PCIs0), .lessthan(lessthan),
        .bus(bus_if.master),
        .Active(Active), .State(State), .IorD(IorD), .IrWrite(IrWrite), .IrSel(IrSel),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ALUSel(ALUSel),
        .ExtSel(ExtSel), .PCWrite(PCWrite), .PCSrc(PCSrc), .Is_Jump(Is_Jump),
        .BranchDelay(BranchDelay), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .Link(Link), .OutLSB(OutLSB), .extendedmem(extendedmem), .stall(stall), .Stall(Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        lt;
        int          fw;
        int          mw;
        logic [4:0]  alu;
        logic [1:0]  srcb;
        logic        jmp;
        logic        taken;
        logic        mem;
        logic        wr;
        logic        rw, rd, m2r, link, lsb;
        logic [1:0]  em;
        logic        es;
    } vec_t;

    typedef struct {
        string       name;
        logic [14:0] wb;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    sb_t  mon_it;
    int   checks   = 0;
    int   failures = 0;
    logic model_bd = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] instr, input logic lt,
                                input int fw, input int mw, input logic [4:0] alu,
                                input logic [1:0] srcb, input logic jmp, input logic taken,
                                input logic mem, input logic wr, input logic rw, input logic rd,
                                input logic m2r, input logic link, input logic lsb,
                                input logic [1:0] em, input logic es);
        vec_t v;
        v.name = name; v.instr = instr; v.lt = lt; v.fw = fw; v.mw = mw;
        v.alu = alu; v.srcb = srcb; v.jmp = jmp; v.taken = taken; v.mem = mem; v.wr = wr;
        v.rw = rw; v.rd = rd; v.m2r = m2r; v.link = link; v.lsb = lsb; v.em = em; v.es = es;
        return v;
    endfunction

    // WB scoreboard: compare control outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (!Rst && State == 3'd4) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected actual=WB-with-no-instruction-queued expected=none");
            end else begin
                mon_it = sb.pop_front();
                chk({"wb_", mon_it.name},
                    {17'd0, RegWrite, RegDst, MemtoReg, Link, OutLSB, extendedmem, ExtSel,
                     PCSrc, PCWrite, ALUControl},
                    {17'd0, mon_it.wb});
            end
        end
    end

    task automatic exec_instr(input vec_t v);
        logic exp_pcsrc;
        sb_t  it;
        PCIs0 = 1'b0;
        for (int i = 0; i < v.fw; i++) begin
            bus_if.waitrequest = 1'b1;
            #1;
            chk({"fetch_hold_", v.name}, {State, bus_if.MemRead, bus_if.byteenable, stall, Stall, IrWrite},
                {3'd0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0});
            @(posedge clk); #1;
        end
        bus_if.waitrequest = 1'b0;
        #1;
        chk({"fetch_", v.name}, {State, bus_if.MemRead, bus_if.MemWrite, IorD, bus_if.byteenable, IrWrite, IrSel, stall},
            {3'd0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0});
        exp_pcsrc = model_bd & ~v.taken;
        if (v.taken) model_bd = 1'b1;
        else if (exp_pcsrc) model_bd = 1'b0;
        it.name = v.name;
        it.wb   = {v.rw, v.rd, v.m2r, v.link, v.lsb, v.em, v.es, exp_pcsrc, 1'b1, 5'd0};
        sb.push_back(it);
        @(posedge clk); #1;
        Instr    = v.instr;
        lessthan = v.lt;
        #1;
        chk({"decode_", v.name}, {State, ALUSrcA, ALUSrcB, ALUControl}, {3'd1, 1'b0, 2'd1, 5'd0});
        @(posedge clk); #1;
        chk({"exec_", v.name}, {State, ALUControl, ALUSrcB, Is_Jump, bus_if.MemRead, bus_if.MemWrite},
            {3'd2, v.alu, v.srcb, v.jmp, 1'b0, 1'b0});
        if (v.mem) begin
            @(posedge clk); #1;
            for (int i = 0; i < v.mw; i++) begin
                bus_if.waitrequest = 1'b1;
                #1;
                chk({"mem_hold_", v.name}, {State, bus_if.MemRead, bus_if.MemWrite, IorD, stall},
                    {3'd3, ~v.wr, v.wr, 1'b1, 1'b1});
                @(posedge clk); #1;
            end
            bus_if.waitrequest = 1'b0;
            #1;
            chk({"mem_", v.name}, {State, bus_if.MemRead, bus_if.MemWrite, IorD, bus_if.byteenable, stall},
                {3'd3, ~v.wr, v.wr, 1'b1, 4'hF, 1'b0});
        end
        @(posedge clk); #1;
        chk({"wb_state_", v.name}, {29'd0, State}, 32'd4);
        @(posedge clk); #1;
        chk({"after_", v.name}, {State, BranchDelay}, {3'd0, model_bd});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                name      instr         lt fw mw alu   sb jm tk me wr rw rd m2 lk ls em es
        vecs.push_back(mk("addiu",  32'h24020005, 0, 3, 0, 5'd0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("addu",   32'h00221821, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("subu",   32'h00221823, 0, 0, 0, 5'd1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("and",    32'h00221824, 0, 0, 0, 5'd2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("or",     32'h00221825, 0, 0, 0, 5'd3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("xor",    32'h00221826, 0, 0, 0, 5'd4, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("slt",    32'h0022182A, 0, 0, 0, 5'd5, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk("sltu",   32'h0022182B, 0, 0, 0, 5'd6, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk("sll",    32'h00021900, 0, 0, 0, 5'd7, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("srl",    32'h00021902, 0, 0, 0, 5'd8, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("sra",    32'h00021903, 0, 0, 0, 5'd9, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("andi",   32'h302200FF, 0, 0, 0, 5'd2, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("ori",    32'h342200FF, 0, 0, 0, 5'd3, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("xori",   32'h382200FF, 0, 0, 0, 5'd4, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("slti",   32'h282200FF, 0, 0, 0, 5'd5, 2, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk("sltiu",  32'h2C2200FF, 0, 0, 0, 5'd6, 2, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk("lui",    32'h3C021234, 0, 0, 0, 5'd10, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("lw",     32'h8C220004, 0, 0, 0, 5'd0, 2, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk("lb",     32'h80220004, 0, 0, 2, 5'd0, 2, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk("lbu",    32'h90220004, 0, 0, 0, 5'd0, 2, 0, 0, 1, 0, 1, 0, 1, 0, 0, 2, 0));
        vecs.push_back(mk("lh",     32'h84220004, 0, 0, 0, 5'd0, 2, 0, 0, 1, 0, 1, 0, 1, 0, 0, 3, 1));
        vecs.push_back(mk("lhu",    32'h94220004, 0, 0, 0, 5'd0, 2, 0, 0, 1, 0, 1, 0, 1, 0, 0, 3, 0));
        vecs.push_back(mk("sw",     32'hAC220004, 0, 0, 2, 5'd0, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("unk",    32'hFC000000, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("beq_t",  32'h10220003, 1, 0, 0, 5'd11, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("slot1",  32'h00221821, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("beq_nt", 32'h10220003, 0, 0, 0, 5'd11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("seq2",   32'h00221821, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("bne_t",  32'h14220003, 1, 0, 0, 5'd12, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("bne_t2", 32'h14220003, 1, 0, 0, 5'd12, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("slot3",  32'h00221821, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("jal",    32'h0C000010, 0, 0, 0, 5'd0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk("slot4",  32'h00221821, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("j",      32'h08000010, 0, 0, 0, 5'd0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("jalr",   32'h0020F809, 0, 0, 0, 5'd13, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk("slot5",  32'h00221821, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));

        Rst = 1'b1;
        Instr = 32'h0;
        PCIs0 = 1'b0;
        lessthan = 1'b0;
        bus_if.waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {State, Active, BranchDelay, bus_if.MemRead, bus_if.MemWrite, bus_if.byteenable,
                      PCWrite, IrWrite, RegWrite, stall},
            {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        Rst = 1'b0;

        foreach (vecs[i]) exec_instr(vecs[i]);

        // Taken branch, then a load in its delay slot reset while MEM is stalled.
        exec_instr(mk("beq_r", 32'h10220003, 1, 0, 0, 5'd11, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        bus_if.waitrequest = 1'b0;
        @(posedge clk); #1;
        Instr = 32'h8C220004;
        lessthan = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_if.waitrequest = 1'b1;
        #1;
        chk("rst_mem_wait", {State, bus_if.MemRead, stall, BranchDelay}, {3'd3, 1'b1, 1'b1, 1'b1});
        Rst = 1'b1;
        #1;
        chk("rst_mem_drop", {bus_if.MemRead, bus_if.MemWrite, IorD, stall, bus_if.byteenable}, 8'h00);
        @(posedge clk); #1;
        Rst = 1'b0;
        bus_if.waitrequest = 1'b0;
        model_bd = 1'b0;
        chk("rst_mem_after", {State, BranchDelay, Active}, {3'd0, 1'b0, 1'b1});

        // JR to address 0, its delay slot, then halt on the next fetch.
        exec_instr(mk("jr0", 32'h00200008, 0, 0, 0, 5'd13, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        exec_instr(mk("slot6", 32'h00221821, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        PCIs0 = 1'b1;
        #1;
        chk("halt_fetch", {State, bus_if.MemRead, IrWrite}, {3'd0, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("halt", {State, Active, bus_if.MemRead, bus_if.MemWrite, PCWrite, RegWrite},
                {3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        Rst = 1'b1;
        @(posedge clk); #1;
        Rst = 1'b0;
        PCIs0 = 1'b0;
        chk("halt_reset", {State, Active}, {3'd0, 1'b1});
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_control_decoder.md
# mips_control_decoder

Multicycle control unit for the Avalon-bus MIPS-I CPU. It sequences fetch/decode/execute/memory/writeback, decodes the instruction word into datapath control strobes, and drives the bus read/write strobes and byte enables. It handles the branch delay slot and halts the CPU when execution reaches address 0. It sits beside the datapath inside the CPU top level and holds all control state.

## Interface
Parameters: none.
- clk  in  1  system clock, all state on rising edge
- Rst  in  1  synchronous, active-high reset
- Instr  in  32  current instruction register contents from datapath
- waitrequest  in  1  bus stall; current read/write not accepted while high
- PCIs0  in  1  datapath flag: PC == 0x00000000
- lessthan  in  1  datapath compare flag (ALU compare result true)
- Active  out  1  CPU running; 0 once halted
- State  out  3  current FSM state (encoding below)
- MemRead / MemWrite  out  1  bus read / write strobes
- byteenable  out  4  bus byte lanes
- IorD  out  1  address mux: 0 = PC, 1 = ALUOut
- IrWrite, IrSel  out  1  load IR; IrSel=1 selects readdata, 0 holds
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  0 = rt, 1 = constant 4, 2 = extended imm, 3 = shamt
- ALUControl  out  5  ALU op (encoding below)
- ALUSel  out  1  ALU result source for PC: 0 = ALU, 1 = ALUOut
- ExtSel  out  1  immediate extension: 1 = sign, 0 = zero
- PCWrite, PCSrc, Is_Jump  out  1  PC enable; PCSrc=1 loads BranchNext; Is_Jump=1 computes jump target
- BranchDelay  out  1  taken branch/jump pending, current instruction is delay slot
- RegWrite, RegDst, MemtoReg, Link  out  1  regfile write; dest 1=rd/0=rt; data from memory; Link forces dest 31 and data PC+8
- OutLSB  out  1  write only compare bit, zero-extended (SLT family)
- extendedmem  out  2  load extraction: 0 word, 1 signed byte, 2 unsigned byte, 3 signed half (LHU uses 3 with ExtSel=0)
- stall, Stall  out  1  high while a bus access is held by waitrequest (identical)

## Operation
- ALUControl: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 LUI, 11 EQ, 12 NE, 13 PASSA.
- Supported instructions: ADDU SUBU AND OR XOR SLT SLTU SLL SRL SRA JR JALR, ADDIU ANDI ORI XORI SLTI SLTIU LUI, LW LB LBU LH LHU SW, BEQ BNE J JAL.
- ExtSel = 0 for ANDI/ORI/XORI/LHU/LBU, else 1. Unknown opcode is executed as NOP.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- FETCH: if PCIs0, go HALT with no bus access. Otherwise MemRead=1, IorD=0, byteenable=1111. Stay while waitrequest. On accept: IrWrite=1, IrSel=1, then DECODE.
- DECODE: compute PC+4 into ALUOut, then EXEC.
- EXEC, ALU ops: result to ALUOut, then WB.
- EXEC, loads/stores: address = rs + sign-extended imm, then MEM.
- EXEC, BEQ/BNE: ALUControl EQ/NE on rs, rt. If lessthan, BranchNext latches PC+4+(imm<<2) and BranchDelay is set.
- EXEC, J/JAL/JR/JALR: always taken. Target is {PC[31:28], imm26, 00} (Is_Jump=1) or rs; BranchDelay is set. JAL/JALR also do the link write. Go to WB.
- MEM: MemRead (loads) or MemWrite (SW, byteenable 1111), IorD=1. Hold while waitrequest, then WB.
- WB: RegWrite if the instruction writes; MemtoReg for loads. Then PCWrite=1:
  - BranchDelay set and this is not the branch itself: PCSrc=1 (PC ← BranchNext), clear BranchDelay.
  - Otherwise: PC ← PC+4.
  - Then FETCH.
- HALT: Active=0, all strobes 0. Only Rst leaves HALT.

## Timing
- Reset: State=FETCH, Active=1, BranchDelay=0, all strobes and enables 0, byteenable=0000. The first fetch read is asserted the cycle after Rst deasserts.
- MemRead/MemWrite are never high together. Both are held stable with constant address while waitrequest=1.
- Instruction latency with no wait states: ALU/branch/jump 4 cycles, load/store 5 cycles.
- Branch followed by a branch in its delay slot: the second branch's target wins. BranchNext is overwritten and BranchDelay stays set.
- Rst in any state, including MEM while waitrequest is high: the next state is FETCH and the strobes drop the same cycle.
- Jump to 0 (JR with rs=0): the delay slot executes, then HALT on the next FETCH.

## Test plan
- Reset then ADDIU v0,zero,5 at PC 0xBFC00000 → FETCH→DECODE→EXEC→WB; RegWrite=1, RegDst=0, ALUControl=0 in WB; read asserted once with byteenable 1111.
- FETCH with waitrequest high for 3 cycles → State stays 0, MemRead held, stall=1, IrWrite pulses only on the accept cycle.
- LB instruction → MEM state with IorD=1, MemRead=1; WB has MemtoReg=1, extendedmem=1, ExtSel=1.
- BEQ with lessthan=1 followed by ADDU → delay slot's WB has PCSrc=1 and BranchDelay falls to 0; with lessthan=0, PCSrc stays 0.
- JAL → Link=1 and RegWrite=1 in WB, Is_Jump=1 in EXEC, BranchDelay=1 afterwards.
- JR to 0 then delay slot, PCIs0=1 at FETCH → State=7, Active=0, no further MemRead; Rst returns Active=1, State=0.
